player_ctrl: RTL and testbench

//  Upstream of the laser sprite stage: turns raw pad buttons into player_x/player_y and the

---
 rtl/stg_defs.sv | 31 +++
 rtl/btn_sync.sv | 23 ++
 rtl/player_ctrl.sv | 136 +++++++++++++
 tb/tb_player_ctrl.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/stg_defs.sv
// Shared playfield geometry and laser FSM encoding for the player/laser stages.
package stg_defs;

    localparam int MAX_X   = 384;
    localparam int MAX_Y   = 448;
    localparam int HALF_W  = 8;
    localparam int HALF_H  = 12;
    localparam int SPAWN_X = 192;
    localparam int SPAWN_Y = 400;

    localparam logic signed [10:0] X_LO = 11'(HALF_W);
    localparam logic signed [10:0] X_HI = 11'(MAX_X - 1 - HALF_W);
    localparam logic signed [10:0] Y_LO = 11'(HALF_H);
    localparam logic signed [10:0] Y_HI = 11'(MAX_Y - 1 - HALF_H);

    typedef enum logic [1:0] {
        READY    = 2'd0,
        FIRING   = 2'd1,
        OVERHEAT = 2'd2
    } laser_state_e;

    // Signed compare so a step past zero clamps to lo instead of wrapping.
    function automatic logic [9:0] clamp_pos(input logic signed [10:0] v,
                                             input logic signed [10:0] lo,
                                             input logic signed [10:0] hi);
        if (v < lo) return lo[9:0];
        if (v > hi) return hi[9:0];
        return v[9:0];
    endfunction

endpackage

// File: rtl/btn_sync.sv
// Two-flop synchroniser for a bus of independent asynchronous button inputs.
module btn_sync #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta <= '0;
            dout <= '0;
        end else begin
            meta <= din;
            dout <= meta;
        end
    end

endmodule

// File: rtl/player_ctrl.sv
// Player ship controller: button sync, tick-rate movement with clamping, laser energy FSM.
//   state    | meaning
//   READY    | laser idle, energy recharging on ticks
//   FIRING   | laser active, energy draining on ticks
//   OVERHEAT | fire locked out until energy is full again
module player_ctrl
    import stg_defs::*;
#(
    parameter int TICK_DIV   = 2000000,
    parameter int STEP_FAST  = 3,
    parameter int STEP_SLOW  = 1,
    parameter int ENERGY_MAX = 255,
    parameter int DRAIN      = 2,
    parameter int RECHARGE   = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_fire,
    input  logic       btn_focus,
    output logic [9:0] player_x,
    output logic [9:0] player_y,
    output logic       shooting,
    output logic       overheat,
    output logic [7:0] energy,
    output logic       game_tick
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] TC_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [8:0] E_MAX9  = 9'(ENERGY_MAX);
    localparam logic [7:0] E_MAX8  = 8'(ENERGY_MAX);
    localparam logic [8:0] E_DRN9  = 9'(DRAIN);
    localparam logic [7:0] E_DRN8  = 8'(DRAIN);
    localparam logic [8:0] E_RCH9  = 9'(RECHARGE);

    logic [5:0] btn_s;
    logic       up_s, down_s, left_s, right_s, fire_s, focus_s;

    btn_sync #(.WIDTH(6)) u_btn_sync (
        .clk   (clk),
        .reset (reset),
        .din   ({btn_focus, btn_fire, btn_right, btn_left, btn_down, btn_up}),
        .dout  (btn_s)
    );

    assign {focus_s, fire_s, right_s, left_s, down_s, up_s} = btn_s;

    logic [CNT_W-1:0] tick_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tick_cnt  <= '0;
            game_tick <= 1'b0;
        end else begin
            game_tick <= (tick_cnt == TC_LAST);
            tick_cnt  <= (tick_cnt == TC_LAST) ? '0 : tick_cnt + 1'b1;
        end
    end

    logic signed [10:0] step, dx, dy, x_new, y_new;

    always_comb begin
        step = focus_s ? 11'(STEP_SLOW) : 11'(STEP_FAST);
        dx   = '0;
        dy   = '0;
        if (right_s && !left_s)      dx = step;
        else if (left_s && !right_s) dx = -step;
        if (down_s && !up_s)         dy = step;
        else if (up_s && !down_s)    dy = -step;
        x_new = $signed({1'b0, player_x}) + dx;
        y_new = $signed({1'b0, player_y}) + dy;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            player_x <= 10'(SPAWN_X);
            player_y <= 10'(SPAWN_Y);
        end else if (game_tick) begin
            player_x <= clamp_pos(x_new, X_LO, X_HI);
            player_y <= clamp_pos(y_new, Y_LO, Y_HI);
        end
    end

    laser_state_e state, state_nx;
    logic [7:0]   energy_nx, e_up_sat, e_dn;
    logic [8:0]   e_up;

    always_comb begin
        state_nx  = state;
        energy_nx = energy;
        e_up      = {1'b0, energy} + E_RCH9;
        e_up_sat  = (e_up >= E_MAX9) ? E_MAX8 : e_up[7:0];
        e_dn      = ({1'b0, energy} >= E_DRN9) ? (energy - E_DRN8) : 8'd0;
        case (state)
            READY: begin
                if (game_tick) energy_nx = e_up_sat;
                if (fire_s && ({1'b0, energy} >= E_DRN9)) state_nx = FIRING;
            end
            FIRING: begin
                // Releasing fire wins over a coincident tick, so no drain is charged.
                if (!fire_s) begin
                    state_nx = READY;
                end else if (game_tick) begin
                    energy_nx = e_dn;
                    if ({1'b0, e_dn} < E_DRN9) state_nx = OVERHEAT;
                end
            end
            OVERHEAT: begin
                if (game_tick) begin
                    energy_nx = e_up_sat;
                    if ({1'b0, e_up_sat} >= E_MAX9) state_nx = READY;
                end
            end
            default: state_nx = READY;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= READY;
            energy   <= E_MAX8;
            shooting <= 1'b0;
            overheat <= 1'b0;
        end else begin
            state    <= state_nx;
            energy   <= energy_nx;
            shooting <= (state == FIRING);
            overheat <= (state == OVERHEAT);
        end
    end

endmodule

// File: tb/tb_player_ctrl.sv
// Randomised bench for player_ctrl against a cycle-level behavioural model.
module tb_player_ctrl;

    localparam int T    = 4;
    localparam int DR   = 2;
    localparam int RC   = 1;
    localparam int EMAX = 255;
    localparam int XL = 8, XH = 375, YL = 12, YH = 435;
    localparam int M_READY = 0, M_FIRING = 1, M_OVH = 2;

    localparam logic [5:0] B_UP = 6'b000001, B_DOWN = 6'b000010, B_LEFT = 6'b000100;
    localparam logic [5:0] B_RIGHT = 6'b001000, B_FIRE = 6'b010000, B_FOCUS = 6'b100000;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] drv;
    logic [9:0] player_x, player_y;
    logic [7:0] energy;
    logic       shooting, overheat, game_tick;

    always #5 clk = ~clk;

    player_ctrl #(
        .TICK_DIV(T), .STEP_FAST(3), .STEP_SLOW(1),
        .ENERGY_MAX(EMAX), .DRAIN(DR), .RECHARGE(RC)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .btn_up    (drv[0]),
        .btn_down  (drv[1]),
        .btn_left  (drv[2]),
        .btn_right (drv[3]),
        .btn_fire  (drv[4]),
        .btn_focus (drv[5]),
        .player_x  (player_x),
        .player_y  (player_y),
        .shooting  (shooting),
        .overheat  (overheat),
        .energy    (energy),
        .game_tick (game_tick)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: positions/energy as plain integers, buttons delayed by a 2-deep queue.
    int         m_x, m_y, m_e, m_st, m_cnt;
    bit         m_tick, m_shoot, m_ovh;
    logic [5:0] m_q[$];

    function automatic int clampi(input int v, input int lo, input int hi);
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

    task automatic model_reset();
        m_x = 192; m_y = 400; m_e = EMAX; m_st = M_READY;
        m_cnt = 0; m_tick = 0; m_shoot = 0; m_ovh = 0;
        m_q.delete();
        m_q.push_back(6'd0);
        m_q.push_back(6'd0);
    endtask

    task automatic model_edge(input logic [5:0] raw);
        logic [5:0] b;
        bit tk;
        int st0, e0, step, dx, dy, eu, ed;
        b = m_q.pop_front();
        m_q.push_back(raw);
        tk = m_tick;
        st0 = m_st;
        e0 = m_e;
        m_tick = (m_cnt == T - 1);
        m_cnt = (m_cnt + 1) % T;
        if (tk) begin
            step = b[5] ? 1 : 3;
            dx = (b[3] && !b[2]) ? step : ((b[2] && !b[3]) ? -step : 0);
            dy = (b[1] && !b[0]) ? step : ((b[0] && !b[1]) ? -step : 0);
            m_x = clampi(m_x + dx, XL, XH);
            m_y = clampi(m_y + dy, YL, YH);
        end
        eu = (e0 + RC > EMAX) ? EMAX : e0 + RC;
        ed = (e0 >= DR) ? e0 - DR : 0;
        if (st0 == M_READY) begin
            if (tk) m_e = eu;
            if (b[4] && e0 >= DR) m_st = M_FIRING;
        end else if (st0 == M_FIRING) begin
            if (!b[4]) m_st = M_READY;
            else if (tk) begin
                m_e = ed;
                if (ed < DR) m_st = M_OVH;
            end
        end else begin
            if (tk) begin
                m_e = eu;
                if (eu == EMAX) m_st = M_READY;
            end
        end
        m_shoot = (st0 == M_FIRING);
        m_ovh   = (st0 == M_OVH);
    endtask

    // Called at a negedge; applies buttons, steps the model at posedge, compares, returns at negedge.
    task automatic cyc(input logic [5:0] b);
        drv = b;
        @(posedge clk);
        model_edge(b);
        #1;
        chk("x", player_x, m_x);
        chk("y", player_y, m_y);
        chk("energy", energy, m_e);
        chk("shooting", shooting, m_shoot);
        chk("overheat", overheat, m_ovh);
        chk("game_tick", game_tick, m_tick);
        @(negedge clk);
    endtask

    task automatic do_reset();
        drv = '0;
        reset = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        int ticks, k, e_rel;
        bit seen;
        logic [5:0] b;
        int hold;

        reset = 1'b1;
        drv = '0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_x", player_x, 192);
        chk("rst_y", player_y, 400);
        chk("rst_energy", energy, 255);
        chk("rst_shoot", shooting, 0);
        chk("rst_tick", game_tick, 0);
        reset = 1'b0;

        ticks = 0;
        for (int i = 0; i < 20; i++) begin
            cyc('0);
            if (game_tick) ticks++;
        end
        chk("idle_ticks", ticks, 5);
        chk("idle_x", player_x, 192);
        chk("idle_energy", energy, 255);

        // Release fire so the synced release lands on a tick cycle: no drain charged.
        seen = 0;
        for (k = 0; k < 40; k++) begin
            cyc(B_FIRE);
            if (m_st == M_FIRING && m_cnt == T - 2 && k > 4) begin
                seen = 1;
                break;
            end
        end
        chk("rel_setup", seen, 1);
        e_rel = m_e;
        cyc('0);
        cyc('0);
        cyc('0);
        chk("rel_energy", energy, e_rel);
        cyc('0);
        chk("rel_shoot", shooting, 0);

        for (int i = 0; i < 300; i++) cyc(B_RIGHT);
        chk("clamp_xhi", player_x, XH);
        for (int i = 0; i < 700; i++) cyc(B_UP);
        chk("clamp_ylo", player_y, YL);
        for (int i = 0; i < 20; i++) cyc(B_LEFT | B_RIGHT | B_FOCUS);
        chk("lr_hold", player_x, XH);
        for (int i = 0; i < 600; i++) cyc(B_LEFT);
        chk("clamp_xlo", player_x, XL);
        for (int i = 0; i < 600; i++) cyc(B_DOWN);
        chk("clamp_yhi", player_y, YH);

        // Fire until overheat, then keep fire held through the full recharge.
        seen = 0;
        for (int i = 0; i < 800; i++) begin
            cyc(B_FIRE);
            if (overheat) begin
                seen = 1;
                break;
            end
        end
        chk("ovh_reached", seen, 1);
        chk("ovh_energy", energy, 1);
        chk("ovh_shoot", shooting, 0);
        seen = 0;
        for (int i = 0; i < 1200; i++) begin
            cyc(B_FIRE);
            if (!overheat) begin
                seen = 1;
                break;
            end
        end
        chk("ovh_cleared", seen, 1);
        chk("ovh_full", energy, 255);
        cyc(B_FIRE);
        chk("refire", shooting, 1);

        b = '0;
        hold = 0;
        for (int i = 0; i < 3000; i++) begin
            if (hold == 0) begin
                b = 6'($urandom);
                if ($urandom_range(0, 3) == 0) b[4] = 1'b1;
                hold = $urandom_range(1, 12);
            end
            cyc(b);
            hold--;
        end

        do_reset();
        seen = 0;
        for (int i = 0; i < 300; i++) begin
            cyc(B_RIGHT);
            if (m_x >= 300) begin
                seen = 1;
                break;
            end
        end
        chk("steer_x", seen, 1);
        for (int i = 0; i < 12; i++) cyc(B_FIRE);
        chk("mid_shoot_pre", shooting, 1);
        #2;
        reset = 1'b1;
        #1;
        chk("mid_x", player_x, 192);
        chk("mid_y", player_y, 400);
        chk("mid_energy", energy, 255);
        chk("mid_shoot", shooting, 0);
        chk("mid_ovh", overheat, 0);
        chk("mid_tick", game_tick, 0);
        model_reset();
        drv = '0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 12; i++) cyc('0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
